// File: rtl/stopwatch_display_n.sv
// BCD stopwatch with run/stop FSM, preset/count modes and a
// multiplexed, active-low seven-segment display driver.
module stopwatch_display_n #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 1000000,
  parameter int SCAN_DIV   = 100000,
  parameter int DP_POS     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startstop,
  input  logic [1:0]              mode,
  input  logic [4*NUM_DIGITS-1:0] preset,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              sseg,
  output logic                    dp,
  output logic                    running,
  output logic                    done
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [W-1:0]  NINES    = {NUM_DIGITS{4'h9}};
  localparam logic [TW-1:0] TICK_TOP = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_TOP = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_TOP  = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] IDX_DP   = IW'(DP_POS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          ss_q;
  logic          ss_rise;
  logic [1:0]    mode_q;
  logic          mode_chg;
  logic          count_up;
  logic [W-1:0]  clamp;
  logic [W-1:0]  start_val;
  logic [W-1:0]  cnt_q;
  logic [W-1:0]  stepped;
  logic          step_done;
  logic [3:0]    step_dig;
  logic          cy;
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  logic [NUM_DIGITS-1:0] lz;
  logic          lz_run;
  logic [3:0]    cur_digit;
  logic          cur_blank;
  logic [6:0]    seg_dec;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]    sseg_q;
  logic          dp_q;

  assign tick     = (tick_cnt == TICK_TOP);
  assign ss_rise  = startstop & ~ss_q;
  assign mode_chg = (mode != mode_q);
  assign count_up = ~mode_q[1];

  // free-running count-step divider
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // input history for edge and mode-change detection
  always_ff @(posedge clk) begin
    ss_q   <= startstop;
    mode_q <= mode;
  end

  // start value: preset digits saturate at 9
  always_comb begin
    clamp = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (preset[4*i +: 4] > 4'd9) begin
        clamp[4*i +: 4] = 4'd9;
      end else begin
        clamp[4*i +: 4] = preset[4*i +: 4];
      end
    end
    unique case (mode)
      2'b00:   start_val = '0;
      2'b01:   start_val = clamp;
      2'b10:   start_val = clamp;
      default: start_val = NINES;
    endcase
  end

  // one BCD step with ripple carry/borrow
  always_comb begin
    stepped  = cnt_q;
    step_dig = '0;
    cy       = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      step_dig = cnt_q[4*i +: 4];
      if (cy) begin
        if (count_up) begin
          if (step_dig == 4'd9) begin
            step_dig = 4'd0;
          end else begin
            step_dig = step_dig + 4'd1;
            cy       = 1'b0;
          end
        end else begin
          if (step_dig == 4'd0) begin
            step_dig = 4'd9;
          end else begin
            step_dig = step_dig - 4'd1;
            cy       = 1'b0;
          end
        end
      end
      stepped[4*i +: 4] = step_dig;
    end
    step_done = count_up ? (stepped == NINES)
                         : (stepped == '0);
  end

  // run-state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // run-state transitions; a finishing step beats a toggle
  always_comb begin
    state_d = state_q;
    if (mode_chg) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ss_rise) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tick && step_done) begin
            state_d = ST_DONE;
          end else if (ss_rise) begin
            state_d = ST_IDLE;
          end
        end
        ST_DONE: begin
          if (ss_rise) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // status outputs decoded from the run state
  always_comb begin
    running = (state_q == ST_RUN);
    done    = (state_q == ST_DONE);
  end

  // count register: reload, step or hold
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= start_val;
    end else if (mode_chg) begin
      cnt_q <= start_val;
    end else if (state_q == ST_RUN && tick) begin
      cnt_q <= stepped;
    end else if (state_q == ST_DONE && ss_rise) begin
      cnt_q <= start_val;
    end
  end

  // digit scan timer and index
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_TOP) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_TOP) ? '0 : idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // leading-zero map and current digit select
  always_comb begin
    lz     = '0;
    lz_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run && (cnt_q[4*i +: 4] == 4'd0);
      lz[i]  = lz_run;
    end
    cur_digit = '0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_digit = cnt_q[4*i +: 4];
        cur_blank = blank_lz && lz[i] && (i > DP_POS);
      end
    end
  end

  // active-low segment decode, g..a
  always_comb begin
    unique case (cur_digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b1111111;
    endcase
  end

  // registered display drive
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q   <= '1;
      sseg_q <= 7'b1111111;
      dp_q   <= 1'b1;
    end else begin
      an_q   <= ~(NUM_DIGITS'(1) << idx);
      sseg_q <= cur_blank ? 7'b1111111 : seg_dec;
      dp_q   <= (idx != IDX_DP);
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;
  assign dp   = dp_q;

endmodule

// File: tb/tb_stopwatch_display_n.sv
// Bench for stopwatch_display_n: integer-level reference model
// compared every cycle, plus directed literal checkpoints.
module tb_stopwatch_display_n;

  localparam int N    = 4;
  localparam int TD   = 4;
  localparam int SD   = 2;
  localparam int DP   = 2;
  localparam int MAXV = 9999;

  logic        clk = 1'b0;
  logic        reset;
  logic        startstop;
  logic [1:0]  mode;
  logic [15:0] preset;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        dp;
  logic        running;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000
  };

  always #5 clk = ~clk;

  stopwatch_display_n #(
    .NUM_DIGITS(N),
    .TICK_DIV(TD),
    .SCAN_DIV(SD),
    .DP_POS(DP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .startstop(startstop),
    .mode(mode),
    .preset(preset),
    .blank_lz(blank_lz),
    .an(an),
    .sseg(sseg),
    .dp(dp),
    .running(running),
    .done(done)
  );

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic int start_of(logic [1:0] md,
                                  logic [15:0] pr);
    int s;
    int d;
    s = 0;
    for (int i = 0; i < N; i++) begin
      d = int'(pr[4*i +: 4]);
      if (d > 9) d = 9;
      s += d * (10 ** i);
    end
    if (md == 2'b00) return 0;
    if (md == 2'b11) return MAXV;
    return s;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < N; i++)
      b[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return b;
  endfunction

  // reference model state
  int         m_tc;
  int         m_scan;
  int         m_idx;
  int         m_val;
  bit         m_run;
  bit         m_done;
  logic       m_ss;
  logic [1:0] m_mode;
  logic [3:0] m_an;
  logic [6:0] m_sseg;
  logic       m_dp;
  bit         m_valid = 0;

  always @(posedge clk) begin : model
    int  hi;
    int  sv;
    int  nv;
    bit  tk;
    bit  rise;
    bit  nr;
    bit  nd;
    if (reset) begin
      m_tc    <= 0;
      m_scan  <= 0;
      m_idx   <= 0;
      m_val   <= start_of(mode, preset);
      m_run   <= 0;
      m_done  <= 0;
      m_an    <= 4'hF;
      m_sseg  <= 7'h7F;
      m_dp    <= 1'b1;
      m_ss    <= startstop;
      m_mode  <= mode;
      m_valid <= 1;
    end else begin
      hi = m_val / (10 ** m_idx);
      m_an <= ~(4'b0001 << m_idx);
      if (blank_lz && m_idx > DP && hi == 0)
        m_sseg <= 7'h7F;
      else
        m_sseg <= SEG[hi % 10];
      m_dp <= (m_idx == DP) ? 1'b0 : 1'b1;
      if (m_scan == SD - 1) begin
        m_scan <= 0;
        m_idx  <= (m_idx + 1) % N;
      end else begin
        m_scan <= m_scan + 1;
      end
      tk   = (m_tc == TD - 1);
      m_tc <= tk ? 0 : m_tc + 1;
      rise = startstop && !m_ss;
      m_ss   <= startstop;
      m_mode <= mode;
      sv = start_of(mode, preset);
      if (mode != m_mode) begin
        m_val  <= sv;
        m_run  <= 0;
        m_done <= 0;
      end else begin
        nv = m_val;
        nr = m_run;
        nd = m_done;
        if (tk && m_run) begin
          if (!m_mode[1]) begin
            nv = (m_val + 1) % (MAXV + 1);
            if (nv == MAXV) nd = 1;
          end else begin
            nv = (m_val + MAXV) % (MAXV + 1);
            if (nv == 0) nd = 1;
          end
        end
        if (rise) begin
          if (m_done) begin
            nv = sv;
            nd = 0;
            nr = 0;
          end else begin
            nr = !m_run;
          end
        end
        if (nd && !m_done) nr = 0;
        m_val  <= nv;
        m_run  <= nr;
        m_done <= nd;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("an", an, m_an);
      chk("sseg", sseg, m_sseg);
      chk("dp", dp, m_dp);
      chk("running", running, m_run);
      chk("done", done, m_done);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(logic [1:0] md, logic [15:0] pr);
    reset     = 1'b1;
    mode      = md;
    preset    = pr;
    startstop = 1'b0;
    cyc(2);
  endtask

  task automatic pulse;
    startstop = 1'b1;
    cyc(1);
    startstop = 1'b0;
  endtask

  logic [3:0] an_exp [8] = '{
    4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7
  };

  initial begin
    reset     = 1'b1;
    startstop = 1'b0;
    mode      = 2'b00;
    preset    = 16'h0000;
    blank_lz  = 1'b0;

    do_reset(2'b00, 16'h0000);
    chk("rst_an", an, 4'hF);
    chk("rst_sseg", sseg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_cnt", dut.cnt_q, 16'h0000);

    // up count from zero, then freeze
    reset = 1'b0;
    pulse();
    cyc(39);
    chk("up40_cnt", dut.cnt_q, 16'h0010);
    chk("up40_model", to_bcd(m_val), 16'h0010);
    chk("up40_run", running, 1'b1);
    pulse();
    cyc(8);
    chk("frozen_cnt", dut.cnt_q, 16'h0010);
    chk("frozen_run", running, 1'b0);

    // down count to zero, then reload
    do_reset(2'b10, 16'h0003);
    reset = 1'b0;
    pulse();
    cyc(11);
    chk("dn_cnt", dut.cnt_q, 16'h0000);
    chk("dn_done", done, 1'b1);
    chk("dn_run", running, 1'b0);
    pulse();
    cyc(1);
    chk("reload_cnt", dut.cnt_q, 16'h0003);
    chk("reload_model", to_bcd(m_val), 16'h0003);
    chk("reload_done", done, 1'b0);
    chk("reload_run", running, 1'b0);

    // preset clamp and triple carry
    do_reset(2'b01, 16'h09A9);
    chk("clamp_cnt", dut.cnt_q, 16'h0999);
    reset = 1'b0;
    pulse();
    cyc(3);
    chk("carry_cnt", dut.cnt_q, 16'h1000);
    chk("carry_model", to_bcd(m_val), 16'h1000);

    // leading-zero blanking scan
    blank_lz = 1'b1;
    do_reset(2'b01, 16'h0005);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("scan_an", an, an_exp[i]);
      if (i == 0) chk("scan_d0", sseg, 7'b0010010);
      if (i == 4) begin
        chk("scan_d2", sseg, 7'b1000000);
        chk("scan_dp", dp, 1'b0);
      end
      if (i == 6) chk("scan_blank", sseg, 7'h7F);
    end
    blank_lz = 1'b0;

    // reset mid-run
    do_reset(2'b00, 16'h0000);
    reset = 1'b0;
    pulse();
    cyc(167);
    chk("mid_cnt", dut.cnt_q, 16'h0042);
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_cnt", dut.cnt_q, 16'h0000);
    chk("mid_rst_run", running, 1'b0);
    chk("mid_rst_an", an, 4'hF);

    // mode change overrides a running count
    reset = 1'b0;
    pulse();
    cyc(10);
    mode = 2'b11;
    cyc(1);
    chk("mchg_cnt", dut.cnt_q, 16'h9999);
    chk("mchg_run", running, 1'b0);
    chk("mchg_done", done, 1'b0);
    pulse();
    cyc(12);

    // up count to the all-nines limit
    do_reset(2'b00, 16'h0000);
    reset = 1'b0;
    pulse();
    cyc(39991);
    chk("lim_pre_cnt", dut.cnt_q, 16'h9998);
    chk("lim_pre_run", running, 1'b1);
    cyc(4);
    chk("lim_cnt", dut.cnt_q, 16'h9999);
    chk("lim_done", done, 1'b1);
    chk("lim_run", running, 1'b0);
    cyc(8);
    chk("lim_hold", dut.cnt_q, 16'h9999);
    chk("lim_hold_model", to_bcd(m_val), 16'h9999);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
